// File: rtl/cache_fill_ctrl.sv
// Cache fill controller: single-port lookup, write-through/write-allocate fill
// from main memory, with an ack timeout and saturating hit/miss statistics.
module cache_fill_ctrl #(
  parameter int COUNT_W     = 16,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic               clk_1,
  input  logic               rst,
  input  logic               req,
  input  logic               w_rd,
  input  logic [15:0]        address,
  input  logic [7:0]         wdata,
  output logic [7:0]         rdata,
  output logic               ready,
  output logic               err,
  output logic [15:0]        cache_addr,
  output logic               cache_w_rd,
  output logic [7:0]         cache_wdata,
  input  logic [7:0]         cache_rdata,
  input  logic               cache_hit,
  output logic               mem_req,
  output logic               mem_we,
  output logic [15:0]        mem_addr,
  output logic [7:0]         mem_wdata,
  input  logic [7:0]         mem_rdata,
  input  logic               mem_ack,
  output logic [COUNT_W-1:0] hit_cnt,
  output logic [COUNT_W-1:0] miss_cnt
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOOKUP = 3'd1;
  localparam logic [2:0] MEM_RD = 3'd2;
  localparam logic [2:0] MEM_WR = 3'd3;
  localparam logic [2:0] FILL   = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;

  // The wait counter only has to reach ACK_TIMEOUT-1 (the last allowed cycle).
  localparam int              WAIT_W    = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);

  logic [2:0]        state_r;
  logic [2:0]        state_nxt_s;
  logic [WAIT_W-1:0] wait_r;
  logic              wr_r;
  logic [7:0]        wdata_r;
  logic              to_r;
  logic              ack_ok_s;
  logic              timeout_s;
  logic              mem_nxt_s;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    sat_inc = (&v) ? v : v + COUNT_W'(1);
  endfunction

  // Next-state decode; an ack in the timeout cycle wins over the timeout.
  always_comb begin
    state_nxt_s = state_r;
    ack_ok_s    = 1'b0;
    timeout_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (req) state_nxt_s = LOOKUP;
        else     state_nxt_s = IDLE;
      end
      LOOKUP: begin
        if (wr_r)           state_nxt_s = MEM_WR;
        else if (cache_hit) state_nxt_s = DONE;
        else                state_nxt_s = MEM_RD;
      end
      MEM_RD, MEM_WR: begin
        if (mem_ack) begin
          ack_ok_s    = 1'b1;
          state_nxt_s = FILL;
        end else if (wait_r == WAIT_LAST) begin
          timeout_s   = 1'b1;
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      FILL:    state_nxt_s = DONE;
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
    mem_nxt_s = (state_nxt_s == MEM_RD) || (state_nxt_s == MEM_WR);
  end

  // State, wait counter and the registered control strobes.
  always_ff @(posedge clk_1 or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      wait_r     <= '0;
      ready      <= 1'b0;
      err        <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      cache_w_rd <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      ready      <= (state_r == DONE);
      err        <= (state_r == DONE) && to_r;
      mem_req    <= mem_nxt_s;
      mem_we     <= (state_nxt_s == MEM_WR);
      cache_w_rd <= (state_nxt_s == FILL);
      if (mem_nxt_s && (state_nxt_s == state_r)) wait_r <= wait_r + WAIT_W'(1);
      else                                        wait_r <= '0;
    end
  end

  // Request latching and the address/data paths toward cache, memory and CPU.
  always_ff @(posedge clk_1 or negedge rst) begin
    if (!rst) begin
      cache_addr  <= 16'h0000;
      mem_addr    <= 16'h0000;
      wr_r        <= 1'b0;
      wdata_r     <= 8'h00;
      to_r        <= 1'b0;
      mem_wdata   <= 8'h00;
      cache_wdata <= 8'h00;
      rdata       <= 8'h00;
    end else begin
      case (state_r)
        IDLE: begin
          if (req) begin
            cache_addr <= address;
            wr_r       <= w_rd;
            wdata_r    <= wdata;
            to_r       <= 1'b0;
          end
        end
        LOOKUP: begin
          mem_addr <= cache_addr;
          if (wr_r)           mem_wdata <= wdata_r;
          else if (cache_hit) rdata     <= cache_rdata;
        end
        MEM_RD, MEM_WR: begin
          if (ack_ok_s) begin
            if (wr_r) begin
              cache_wdata <= wdata_r;
            end else begin
              rdata       <= mem_rdata;
              cache_wdata <= mem_rdata;
            end
          end else if (timeout_s) begin
            to_r  <= 1'b1;
            rdata <= 8'h00;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Statistics: reads only, counted at the end of LOOKUP.
  always_ff @(posedge clk_1 or negedge rst) begin
    if (!rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if ((state_r == LOOKUP) && !wr_r) begin
      if (cache_hit) hit_cnt  <= sat_inc(hit_cnt);
      else           miss_cnt <= sat_inc(miss_cnt);
    end
  end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Self-checking bench for cache_fill_ctrl: directed vectors, a reset
// sequence and random transactions against a transaction-level model.
module tb_cache_fill_ctrl;
  localparam int T = 12;

  logic clk_1 = 1'b0;
  logic rst = 1'b0;
  logic req = 1'b0, w_rd = 1'b0, cache_hit = 1'b0, mem_ack = 1'b0;
  logic [15:0] address = 16'h0000;
  logic [7:0]  wdata = 8'h00, cache_rdata = 8'h00, mem_rdata = 8'h00;

  logic [7:0]  rdata, cache_wdata, mem_wdata;
  logic        ready, err, cache_w_rd, mem_req, mem_we;
  logic [15:0] cache_addr, mem_addr, hit_cnt, miss_cnt;

  logic [7:0]  s_rdata, s_cache_wdata, s_mem_wdata;
  logic        s_ready, s_err, s_cache_w_rd, s_mem_req, s_mem_we;
  logic [15:0] s_cache_addr, s_mem_addr;
  logic [1:0]  s_hit_cnt, s_miss_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int m_hits = 0, m_misses = 0;
  logic [7:0] m_rdata = 8'h00;

  typedef struct {
    logic        wr;
    logic [15:0] a;
    logic [7:0]  wd;
    logic        hit;
    logic [7:0]  crd;
    int          ack_n;
    logic [7:0]  mrd;
    int          lat;
    logic [7:0]  rd;
    logic        er;
  } vec_t;

  vec_t tbl[13];

  cache_fill_ctrl #(.COUNT_W(16), .ACK_TIMEOUT(T)) dut (
    .clk_1(clk_1), .rst(rst), .req(req), .w_rd(w_rd), .address(address), .wdata(wdata),
    .rdata(rdata), .ready(ready), .err(err), .cache_addr(cache_addr), .cache_w_rd(cache_w_rd),
    .cache_wdata(cache_wdata), .cache_rdata(cache_rdata), .cache_hit(cache_hit),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt));

  cache_fill_ctrl #(.COUNT_W(2), .ACK_TIMEOUT(T)) sat (
    .clk_1(clk_1), .rst(rst), .req(req), .w_rd(w_rd), .address(address), .wdata(wdata),
    .rdata(s_rdata), .ready(s_ready), .err(s_err), .cache_addr(s_cache_addr), .cache_w_rd(s_cache_w_rd),
    .cache_wdata(s_cache_wdata), .cache_rdata(cache_rdata), .cache_hit(cache_hit),
    .mem_req(s_mem_req), .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .hit_cnt(s_hit_cnt), .miss_cnt(s_miss_cnt));

  always #5 clk_1 = ~clk_1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction-level expectations from the access rules.
  function automatic vec_t expect_of(input vec_t v);
    vec_t r;
    logic rd_hit, tmo;
    r      = v;
    rd_hit = !v.wr && v.hit;
    tmo    = !rd_hit && (v.ack_n >= T);
    r.lat  = rd_hit ? 2 : (tmo ? T + 2 : v.ack_n + 4);
    r.er   = tmo;
    r.rd   = rd_hit ? v.crd : (tmo ? 8'h00 : (v.wr ? m_rdata : v.mrd));
    return r;
  endfunction

  task automatic run_txn(input vec_t v, input logic stray);
    int ready_at, nready, memc, fillc, bad_mem, exp_mem, exp_fill, exp_sat;
    logic err_v;
    logic [7:0] rd_v, fill_d;
    logic [15:0] fill_a;
    logic rd_hit;
    rd_hit   = !v.wr && v.hit;
    exp_mem  = rd_hit ? 0 : ((v.ack_n < T) ? v.ack_n + 1 : T);
    exp_fill = (rd_hit || (v.ack_n >= T)) ? 0 : 1;
    if (!v.wr) begin
      if (v.hit) m_hits++;
      else       m_misses++;
    end
    ready_at = -1; nready = 0; memc = 0; fillc = 0; bad_mem = 0;
    err_v = 1'b0; rd_v = 8'h00; fill_d = 8'h00; fill_a = 16'h0000;

    @(negedge clk_1);
    req = 1'b1; w_rd = v.wr; address = v.a; wdata = v.wd;
    cache_hit = v.hit; cache_rdata = v.crd; mem_rdata = v.mrd;
    for (int n = 1; n <= v.lat + 2; n++) begin
      @(negedge clk_1);
      if (n == 1) begin
        req = 1'b0;
        check("lookup_addr", cache_addr, v.a);
        check("lookup_w_rd", cache_w_rd, 1'b0);
      end
      if (ready) begin
        nready++;
        if (ready_at < 0) begin
          ready_at = n; err_v = err; rd_v = rdata;
        end
      end
      if (mem_req) begin
        memc++;
        if (mem_we !== v.wr || mem_addr !== v.a || (v.wr && mem_wdata !== v.wd)) bad_mem++;
      end
      if (cache_w_rd) begin
        fillc++; fill_d = cache_wdata; fill_a = cache_addr;
      end
      mem_ack = ((v.ack_n < T) && (n == 2 + v.ack_n) && (n <= v.lat + 1)) || (stray && n == 1);
    end
    mem_ack = 1'b0;

    check("ready_cycle", ready_at, v.lat + 1);
    check("ready_pulses", nready, 1);
    check("err", err_v, v.er);
    check("rdata", rd_v, v.rd);
    check("rdata_hold", rdata, v.rd);
    check("mem_cycles", memc, exp_mem);
    check("mem_fields", bad_mem, 0);
    check("fill_cycles", fillc, exp_fill);
    if (exp_fill == 1) begin
      check("fill_data", fill_d, v.wr ? v.wd : v.mrd);
      check("fill_addr", fill_a, v.a);
    end
    check("hit_cnt", hit_cnt, m_hits);
    check("miss_cnt", miss_cnt, m_misses);
    exp_sat = (m_hits > 3) ? 3 : m_hits;
    check("sat_hit_cnt", s_hit_cnt, exp_sat);
    exp_sat = (m_misses > 3) ? 3 : m_misses;
    check("sat_miss_cnt", s_miss_cnt, exp_sat);
    m_rdata = v.rd;
  endtask

  initial begin
    vec_t v;
    //          wr    addr      wd     hit   crd    ack  mrd    lat    rd     er
    tbl[0]  = '{1'b0, 16'h0001, 8'h00, 1'b1, 8'h03, T,   8'h00, 2,     8'h03, 1'b0};
    tbl[1]  = '{1'b0, 16'h1280, 8'h00, 1'b0, 8'h77, 3,   8'hA5, 7,     8'hA5, 1'b0};
    tbl[2]  = '{1'b1, 16'h0300, 8'h5A, 1'b0, 8'h00, 0,   8'h11, 4,     8'hA5, 1'b0};
    tbl[3]  = '{1'b0, 16'h4444, 8'h00, 1'b0, 8'h00, T,   8'h66, T + 2, 8'h00, 1'b1};
    tbl[4]  = '{1'b0, 16'h8001, 8'h00, 1'b0, 8'h00, T-1, 8'hC3, T + 3, 8'hC3, 1'b0};
    tbl[5]  = '{1'b1, 16'h00FF, 8'h9E, 1'b0, 8'h00, T,   8'h00, T + 2, 8'h00, 1'b1};
    tbl[6]  = '{1'b1, 16'hBEEF, 8'h42, 1'b1, 8'h99, 2,   8'h00, 6,     8'h00, 1'b0};
    tbl[7]  = '{1'b0, 16'hFFFF, 8'h00, 1'b1, 8'hFF, T,   8'h00, 2,     8'hFF, 1'b0};
    tbl[8]  = '{1'b0, 16'h0010, 8'h00, 1'b1, 8'h10, 0,   8'hEE, 2,     8'h10, 1'b0};
    tbl[9]  = '{1'b0, 16'h0020, 8'h00, 1'b1, 8'h20, 1,   8'hEE, 2,     8'h20, 1'b0};
    tbl[10] = '{1'b0, 16'h0030, 8'h00, 1'b1, 8'h30, T,   8'h00, 2,     8'h30, 1'b0};
    tbl[11] = '{1'b0, 16'h0040, 8'h00, 1'b0, 8'h00, 0,   8'h4D, 4,     8'h4D, 1'b0};
    tbl[12] = '{1'b1, 16'h0050, 8'h3C, 1'b0, 8'h00, 5,   8'h00, 9,     8'h4D, 1'b0};

    // Reset state, asserted from time zero.
    @(negedge clk_1);
    check("rst_ready", ready, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_cache_w_rd", cache_w_rd, 1'b0);
    check("rst_rdata", rdata, 8'h00);
    check("rst_addrs", {cache_addr, mem_addr}, 32'h0000_0000);
    check("rst_counts", {hit_cnt, miss_cnt}, 32'h0000_0000);
    @(negedge clk_1);
    rst = 1'b1;

    for (int i = 0; i < 13; i++) run_txn(tbl[i], (i == 1));

    // Reset in the middle of a read miss.
    @(negedge clk_1);
    req = 1'b1; w_rd = 1'b0; address = 16'h2222; cache_hit = 1'b0;
    @(negedge clk_1);
    req = 1'b0;
    @(negedge clk_1);
    check("mid_mem_req_up", mem_req, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("mid_mem_req_async", mem_req, 1'b0);
    check("mid_ready_async", ready, 1'b0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_1);
      check("mid_no_ready", ready, 1'b0);
      check("mid_no_fill", cache_w_rd, 1'b0);
      check("mid_counts", {hit_cnt, miss_cnt}, 32'h0000_0000);
    end
    rst = 1'b1;
    m_hits = 0; m_misses = 0; m_rdata = 8'h00;
    run_txn(tbl[0], 1'b0);

    // Random transactions against the model.
    for (int i = 0; i < 40; i++) begin
      v.wr    = 1'($urandom_range(0, 1));
      v.a     = 16'($urandom);
      v.wd    = 8'($urandom);
      v.hit   = 1'($urandom_range(0, 1));
      v.crd   = 8'($urandom);
      v.mrd   = 8'($urandom);
      v.ack_n = $urandom_range(0, T);
      v.lat   = 0; v.rd = 8'h00; v.er = 1'b0;
      v = expect_of(v);
      run_txn(v, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cache_fill_ctrl.md
CACHE_FILL_CTRL -- requirements
Module: cache_fill_ctrl

Interface
REQ-001 SHALL have parameter COUNT_W, default 16, giving the width of the hit and miss counters.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 255, giving the maximum cycles spent waiting for mem_ack.
REQ-003 clk_1  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 req  in  1  CPU access request; sampled only in IDLE.
REQ-006 w_rd  in  1  access type: 1 = write, 0 = read.
REQ-007 address  in  16  CPU byte address.
REQ-008 wdata  in  8  CPU write data.
REQ-009 rdata  out  8  read data returned to the CPU.
REQ-010 ready  out  1  single-cycle completion strobe.
REQ-011 err  out  1  completion with a memory timeout, valid with ready.
REQ-012 cache_addr  out  16  address to the cache.
REQ-013 cache_w_rd  out  1  cache write strobe: 1 = write, 0 = read.
REQ-014 cache_wdata  out  8  fill or write data to the cache.
REQ-015 cache_rdata  in  8  cache read data.
REQ-016 cache_hit  in  1  cache hit flag.
REQ-017 mem_req  out  1  main-memory request, level, held until ack.
REQ-018 mem_we  out  1  memory write enable.
REQ-019 mem_addr  out  16  memory address.
REQ-020 mem_wdata  out  8  memory write data.
REQ-021 mem_rdata  in  8  memory read data, valid with mem_ack.
REQ-022 mem_ack  in  1  single-cycle memory completion.
REQ-023 hit_cnt, miss_cnt  out  COUNT_W each  saturating statistics counters.

Function
REQ-024 SHALL implement the states IDLE, LOOKUP, MEM_RD, MEM_WR, FILL and DONE.
REQ-025 IDLE: SHALL latch address, w_rd and wdata when req=1, go to LOOKUP, and ignore req in every other state.
REQ-026 LOOKUP: SHALL hold for one cycle with cache_addr = latched address and cache_w_rd=0, then sample cache_hit and cache_rdata at its end.
REQ-027 LOOKUP read hit: SHALL load rdata from cache_rdata, increment hit_cnt, and go to DONE.
REQ-028 LOOKUP read miss: SHALL increment miss_cnt and go to MEM_RD.
REQ-029 LOOKUP write: SHALL go to MEM_WR with both counters unchanged (write-through policy).
REQ-030 MEM_RD: SHALL hold mem_req=1, mem_we=0 and mem_addr = latched address, then on mem_ack capture mem_rdata into rdata and go to FILL.
REQ-031 MEM_WR: SHALL hold mem_req=1, mem_we=1 and mem_wdata = latched wdata, then on mem_ack go to FILL.
REQ-032 FILL: SHALL hold for one cycle with cache_w_rd=1, cache_addr = latched address, and cache_wdata = rdata (read miss) or latched wdata (write), then go to DONE (write-allocate).
REQ-033 DONE: SHALL assert ready=1 for exactly one cycle with rdata stable, then go to IDLE; rdata SHALL hold its value until the next completed read.
REQ-034 A read hit SHALL assert ready 2 cycles after the req sample edge; a miss or write with ack after N wait cycles SHALL assert ready N+4 cycles after that edge.
REQ-035 A wait counter SHALL run in MEM_RD/MEM_WR; reaching ACK_TIMEOUT cycles without mem_ack SHALL drop mem_req, skip FILL, and go to DONE with err=1 and rdata=8'h00.
REQ-036 mem_ack outside MEM_RD/MEM_WR SHALL be ignored.
REQ-037 A mem_ack in the same cycle as the timeout SHALL count as success, with err=0.
REQ-038 hit_cnt and miss_cnt SHALL saturate at all-ones and never wrap.
REQ-039 mem_req SHALL be a registered output and SHALL never be asserted outside MEM_RD/MEM_WR.
REQ-040 cache_w_rd SHALL be asserted only in FILL.

Reset
REQ-041 rst=0 SHALL immediately, without waiting for a clock, force IDLE and set ready, err, mem_req, mem_we, cache_w_rd=0, rdata, cache_wdata, mem_wdata=8'h00, cache_addr, mem_addr=16'h0000, and clear both counters and the wait counter.
REQ-042 Reset mid-transaction SHALL abandon the access with no ready pulse and no cache write.
REQ-043 Operation SHALL resume on the first clk_1 rising edge after rst returns to 1.

Verification
REQ-044 Read hit: req, w_rd=0, addr 16'h0001, cache_hit=1, cache_rdata=8'h03 -> ready at +2 cycles, rdata=8'h03, hit_cnt=1, mem_req never asserted.
REQ-045 Read miss: addr 16'h1280, cache_hit=0, mem_ack after 3 cycles with mem_rdata=8'hA5 -> one FILL cycle with cache_wdata=8'hA5, then ready at +7 cycles with rdata=8'hA5 and miss_cnt=1.
REQ-046 Write: w_rd=1, addr 16'h0300, wdata=8'h5A, immediate ack -> mem_we=1, mem_wdata=8'h5A, FILL writes 8'h5A, ready at +4 cycles, both counters unchanged.
REQ-047 Timeout: read miss, no mem_ack -> mem_req high for exactly ACK_TIMEOUT cycles, then ready=1, err=1, rdata=8'h00, and no FILL.
REQ-048 Reset mid-operation: rst=0 during MEM_RD -> mem_req falls with no clock edge, with no ready pulse and no cache write; a following read hit completes normally.
REQ-049 Saturation: COUNT_W=2 and five read hits -> hit_cnt stays at 3.
